// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue stage in front of the ALU. It holds one decoded instruction,
// picks rs2 or the immediate for Y, and bypasses results that are still in
// flight in the EX/MEM and MEM/WB stages. It blocks issue on hazards and
// uses a valid/ready handshake toward decode (in_*) and toward EX/MEM (out_*).
//
// Configuration macro: ALU_FWD_EN
//   defined   : mem/wb bypass onto X/Y; only a load in EX/MEM stalls.
//   undefined : no bypass; any used source matching EX/MEM or MEM/WB stalls.
//               Write-back still refreshes the held operands, so issue
//               resumes the cycle after the producer writes back.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   flush               kill the held instruction (redirect)
//   in_valid/in_ready   handshake with decode
//   in_rs1/rs2_addr     source register addresses (x0 reads as zero)
//   in_rs1/rs2_data     register-file read data
//   in_imm, in_use_imm  immediate and Y-select
//   in_alu_op           ALU select, passed to out_s
//   in_rd_addr/we       destination, passed to out_rd_addr/we
//   in_is_load          load flag, passed to out_is_load
//   mem_*               EX/MEM destination, load flag and result
//   wb_*                MEM/WB destination and write-back data
//   out_valid/out_ready handshake with EX/MEM
//   out_x, out_y, out_s ALU operands and select
//   out_rd_addr/we, out_is_load  registered instruction info
//   hazard_stalls       saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [3:0]        in_alu_op,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic              mem_is_load,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_x,
    output logic [XLEN-1:0]   out_y,
    output logic [3:0]        out_s,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [31:0]       hazard_stalls
);

    // A producer matches a source only if it writes a non-zero register.
    function automatic logic f_match(input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] a,
                                     input logic              we);
        return we && (a != '0) && (a == rs);
    endfunction

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

`ifdef ALU_FWD_EN
    // Youngest producer wins; a load in EX/MEM has no data yet and is
    // handled by the hazard logic instead of the bypass.
    function automatic logic [XLEN-1:0] f_bypass(input logic [REG_AW-1:0] a,
                                                 input logic [XLEN-1:0]   held,
                                                 input logic              mem_hit,
                                                 input logic              mem_ld,
                                                 input logic [XLEN-1:0]   mem_val,
                                                 input logic              wb_hit,
                                                 input logic [XLEN-1:0]   wb_val);
        if (a == '0)
            return '0;
        else if (mem_hit && !mem_ld)
            return mem_val;
        else if (wb_hit)
            return wb_val;
        else
            return held;
    endfunction
`endif

    // Held instruction
    logic              r_full;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_use_imm;
    logic [3:0]        r_alu_op;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_we;
    logic              r_is_load;
    logic [31:0]       r_hazard_stalls;

    // Last values presented while valid, shown whenever out_valid is low
    logic [XLEN-1:0]   r_last_x;
    logic [XLEN-1:0]   r_last_y;
    logic [3:0]        r_last_s;
    logic [REG_AW-1:0] r_last_rd_addr;
    logic              r_last_rd_we;
    logic              r_last_is_load;

    logic              w_mem_hit1;
    logic              w_mem_hit2;
    logic              w_wb_hit1;
    logic              w_wb_hit2;
    logic              w_rs2_used;
    logic              w_hazard;
    logic              w_out_valid;
    logic              w_fire;
    logic              w_in_ready;
    logic              w_capture;
    logic [XLEN-1:0]   w_x;
    logic [XLEN-1:0]   w_y;
    logic              w_cap_wb1;
    logic              w_cap_wb2;

    assign w_mem_hit1 = f_match(r_rs1_addr, mem_rd_addr, mem_rd_we);
    assign w_mem_hit2 = f_match(r_rs2_addr, mem_rd_addr, mem_rd_we);
    assign w_wb_hit1  = f_match(r_rs1_addr, wb_rd_addr, wb_rd_we);
    assign w_wb_hit2  = f_match(r_rs2_addr, wb_rd_addr, wb_rd_we);
    assign w_rs2_used = !r_use_imm;

`ifdef ALU_FWD_EN
    assign w_hazard = mem_is_load && (w_mem_hit1 || (w_rs2_used && w_mem_hit2));

    always_comb begin
        w_x = f_bypass(r_rs1_addr, r_rs1_data, w_mem_hit1, mem_is_load,
                       mem_result, w_wb_hit1, wb_data);
        w_y = r_imm;
        if (!r_use_imm)
            w_y = f_bypass(r_rs2_addr, r_rs2_data, w_mem_hit2, mem_is_load,
                           mem_result, w_wb_hit2, wb_data);
    end
`else
    logic w_unused;
    assign w_unused = ^{1'b0, mem_result, mem_is_load};

    assign w_hazard = w_mem_hit1 || w_wb_hit1 ||
                      (w_rs2_used && (w_mem_hit2 || w_wb_hit2));

    always_comb begin
        w_x = (r_rs1_addr == '0) ? '0 : r_rs1_data;
        w_y = r_imm;
        if (!r_use_imm)
            w_y = (r_rs2_addr == '0) ? '0 : r_rs2_data;
    end
`endif

    assign w_out_valid = r_full && !w_hazard;
    assign w_fire      = w_out_valid && out_ready;
    assign w_in_ready  = !r_full || w_fire;
    assign w_capture   = in_valid && w_in_ready && !flush;

    // Write-through: a register retiring on the capture cycle replaces the
    // stale register-file value being captured.
    assign w_cap_wb1 = f_match(in_rs1_addr, wb_rd_addr, wb_rd_we);
    assign w_cap_wb2 = f_match(in_rs2_addr, wb_rd_addr, wb_rd_we);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full          <= 1'b0;
            r_rs1_addr      <= '0;
            r_rs2_addr      <= '0;
            r_rs1_data      <= '0;
            r_rs2_data      <= '0;
            r_imm           <= '0;
            r_use_imm       <= 1'b0;
            r_alu_op        <= '0;
            r_rd_addr       <= '0;
            r_rd_we         <= 1'b0;
            r_is_load       <= 1'b0;
            r_hazard_stalls <= '0;
            r_last_x        <= '0;
            r_last_y        <= '0;
            r_last_s        <= '0;
            r_last_rd_addr  <= '0;
            r_last_rd_we    <= 1'b0;
            r_last_is_load  <= 1'b0;
        end else begin
            if (flush) begin
                r_full <= 1'b0;
            end else if (w_capture) begin
                r_full     <= 1'b1;
                r_rs1_addr <= in_rs1_addr;
                r_rs2_addr <= in_rs2_addr;
                r_rs1_data <= w_cap_wb1 ? wb_data : in_rs1_data;
                r_rs2_data <= w_cap_wb2 ? wb_data : in_rs2_data;
                r_imm      <= in_imm;
                r_use_imm  <= in_use_imm;
                r_alu_op   <= in_alu_op;
                r_rd_addr  <= in_rd_addr;
                r_rd_we    <= in_rd_we;
                r_is_load  <= in_is_load;
            end else if (w_fire) begin
                r_full <= 1'b0;
            end else if (r_full) begin
                // Stalled: keep held operands current so a producer that
                // retires during the stall is not lost.
                if (w_wb_hit1)
                    r_rs1_data <= wb_data;
                if (w_wb_hit2)
                    r_rs2_data <= wb_data;
            end

            if (r_full && w_hazard && !flush)
                r_hazard_stalls <= f_sat_inc(r_hazard_stalls);

            if (w_out_valid) begin
                r_last_x       <= w_x;
                r_last_y       <= w_y;
                r_last_s       <= r_alu_op;
                r_last_rd_addr <= r_rd_addr;
                r_last_rd_we   <= r_rd_we;
                r_last_is_load <= r_is_load;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_x         = w_out_valid ? w_x       : r_last_x;
    assign out_y         = w_out_valid ? w_y       : r_last_y;
    assign out_s         = w_out_valid ? r_alu_op  : r_last_s;
    assign out_rd_addr   = w_out_valid ? r_rd_addr : r_last_rd_addr;
    assign out_rd_we     = w_out_valid ? r_rd_we   : r_last_rd_we;
    assign out_is_load   = w_out_valid ? r_is_load : r_last_is_load;
    assign hazard_stalls = r_hazard_stalls;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A vector table covers the operand
// selection and hazard decode for a single held instruction; hand-written
// sequences cover reset, write-through, streaming, backpressure, flush,
// stall counting and reset mid-operation. Expectations follow ALU_FWD_EN.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

`ifdef ALU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic        in_is_load;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [3:0]  out_s;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic        out_is_load;
    logic [31:0] hazard_stalls;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_alu_op     (in_alu_op),
        .in_rd_addr    (in_rd_addr),
        .in_rd_we      (in_rd_we),
        .in_is_load    (in_is_load),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_we     (mem_rd_we),
        .mem_is_load   (mem_is_load),
        .mem_result    (mem_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_we      (wb_rd_we),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_s         (out_s),
        .out_rd_addr   (out_rd_addr),
        .out_rd_we     (out_rd_we),
        .out_is_load   (out_is_load),
        .hazard_stalls (hazard_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_stalls;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  op;
        logic [4:0]  mrd;
        logic        mwe;
        logic        mld;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wdat;
        logic        ev;
        logic [31:0] ex;
        logic [31:0] ey;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_side();
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_is_load = 1'b0; mem_result = '0;
        wb_rd_addr  = '0; wb_rd_we  = 1'b0; wb_data     = '0;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic use_imm,
                          input logic [3:0] op, input logic [4:0] rd,
                          input logic rdwe, input logic ld);
        in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_use_imm = use_imm; in_alu_op = op;
        in_rd_addr = rd; in_rd_we = rdwe; in_is_load = ld;
    endtask

    // Present one instruction to an empty stage for one edge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm,
                         input logic [3:0] op);
        set_in(rs1, rs2, d1, d2, imm, use_imm, op, 5'd1, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        //            rs1   rs2   d1        d2        imm           ui  op    mrd  mwe  mld  mres      wrd  wwe  wdat      ev   ex                           ey
        tbl[0]  = '{5'd5, 5'd6, 32'h11,   32'h66,   32'h0,        1'b0, 4'd1, 5'd0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0, 32'h0,    1'b1, 32'h11,  32'h66};
        tbl[1]  = '{5'd5, 5'd6, 32'h11,   32'h66,   32'h0,        1'b0, 4'd2, 5'd5, 1'b1, 1'b0, 32'h22,  5'd5, 1'b1, 32'h33,   FWD,  32'h22,  32'h66};
        tbl[2]  = '{5'd5, 5'd6, 32'h11,   32'h66,   32'h0,        1'b0, 4'd3, 5'd5, 1'b0, 1'b0, 32'h22,  5'd5, 1'b1, 32'h33,   FWD,  32'h33,  32'h66};
        tbl[3]  = '{5'd0, 5'd6, 32'h77,   32'h66,   32'h0,        1'b0, 4'd4, 5'd0, 1'b1, 1'b0, 32'h99,  5'd0, 1'b0, 32'h0,    1'b1, 32'h0,   32'h66};
        tbl[4]  = '{5'd5, 5'd7, 32'h11,   32'h70,   32'hFFFF_FFF0,1'b1, 4'd5, 5'd7, 1'b1, 1'b1, 32'h0,   5'd0, 1'b0, 32'h0,    1'b1, 32'h11,  32'hFFFF_FFF0};
        tbl[5]  = '{5'd5, 5'd7, 32'h11,   32'h70,   32'h0,        1'b0, 4'd6, 5'd7, 1'b1, 1'b1, 32'h0,   5'd0, 1'b0, 32'h0,    1'b0, 32'h0,   32'h0};
        tbl[6]  = '{5'd9, 5'd6, 32'h9999, 32'h66,   32'h0,        1'b0, 4'd7, 5'd9, 1'b0, 1'b1, 32'h5,   5'd0, 1'b0, 32'h0,    1'b1, 32'h9999,32'h66};
        tbl[7]  = '{5'd5, 5'd8, 32'h11,   32'h80,   32'h0,        1'b0, 4'd8, 5'd0, 1'b0, 1'b0, 32'h0,   5'd8, 1'b1, 32'hABCD, FWD,  32'h11,  32'hABCD};
        tbl[8]  = '{5'd3, 5'd6, 32'h333,  32'h66,   32'h0,        1'b0, 4'd9, 5'd4, 1'b1, 1'b0, 32'h44,  5'd2, 1'b1, 32'h22,   1'b1, 32'h333, 32'h66};
        tbl[9]  = '{5'd0, 5'd0, 32'h55,   32'h66,   32'h0,        1'b0, 4'd10,5'd0, 1'b1, 1'b1, 32'h1,   5'd0, 1'b1, 32'h5,    1'b1, 32'h0,   32'h0};
        tbl[10] = '{5'd5, 5'd6, 32'h11,   32'h66,   32'h0,        1'b0, 4'd11,5'd6, 1'b1, 1'b0, 32'h600, 5'd6, 1'b1, 32'h700,  FWD,  32'h11,  32'h600};
        tbl[11] = '{5'd5, 5'd6, 32'h11,   32'h66,   32'h0,        1'b1, 4'd12,5'd5, 1'b1, 1'b1, 32'h0,   5'd0, 1'b0, 32'h0,    1'b0, 32'h0,   32'h0};

        // Reset with decode offering garbage
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        idle_side();
        set_in(5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 4'd0, 5'd3, 1'b1, 1'b0);
        repeat (2) tick();
        in_valid = 1'b0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_stalls", hazard_stalls, 32'd0);
        rst_n = 1'b1;
        tick();
        exp_stalls = 32'd0;

        // Vector table: capture, apply side-stage state, compare, flush
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].rs1, tbl[i].rs2, tbl[i].d1, tbl[i].d2, tbl[i].imm,
                  tbl[i].use_imm, tbl[i].op);
            mem_rd_addr = tbl[i].mrd; mem_rd_we = tbl[i].mwe;
            mem_is_load = tbl[i].mld; mem_result = tbl[i].mres;
            wb_rd_addr = tbl[i].wrd; wb_rd_we = tbl[i].wwe; wb_data = tbl[i].wdat;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_x", i), out_x, tbl[i].ex);
                chk($sformatf("vec%0d_y", i), out_y, tbl[i].ey);
                chk($sformatf("vec%0d_s", i), {28'd0, out_s}, {28'd0, tbl[i].op});
            end
            flush = 1'b1;
            tick();
            flush = 1'b0;
            idle_side();
        end
        chk("table_stalls_flush", hazard_stalls, exp_stalls);

        // Write-through on the capture cycle, plus registered rd/load info
        set_in(5'd4, 5'd0, 32'h1, 32'h0, 32'h0, 1'b1, 4'd13, 5'd9, 1'b1, 1'b1);
        wb_rd_addr = 5'd4; wb_rd_we = 1'b1; wb_data = 32'h44;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        idle_side();
        #1;
        chk("wthru_valid", {31'd0, out_valid}, 32'd1);
        chk("wthru_x", out_x, 32'h44);
        chk("wthru_rd_addr", {27'd0, out_rd_addr}, 32'd9);
        chk("wthru_rd_we", {31'd0, out_rd_we}, 32'd1);
        chk("wthru_is_load", {31'd0, out_is_load}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wthru_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back streaming: one fire per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_in(5'(10 + k), 5'd0, 32'h100 + 32'(k), 32'h0, 32'(k), 1'b1,
                   4'd1, 5'd1, 1'b1, 1'b0);
            #1;
            chk($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            chk($sformatf("stream%0d_valid", k), {31'd0, out_valid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0)
                chk($sformatf("stream%0d_x", k), out_x, 32'h100 + 32'(k - 1));
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_last_x", out_x, 32'h104);
        tick();
        out_ready = 1'b0;
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure for 3 cycles, then flush with a competing in_valid
        issue(5'd12, 5'd0, 32'hAA, 32'h0, 32'h0, 1'b1, 4'd2);
        set_in(5'd13, 5'd0, 32'hBB, 32'h0, 32'h0, 1'b1, 4'd3, 5'd1, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_x", c), out_x, 32'hAA);
            tick();
        end
        set_in(5'd14, 5'd0, 32'hCC, 32'h0, 32'h0, 1'b1, 4'd4, 5'd1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_x_held", out_x, 32'hAA);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("flush_nothing_captured", {31'd0, out_valid}, 32'd0);

`ifdef ALU_FWD_EN
        // Load-use stall resolved by write-back bypass
        issue(5'd5, 5'd7, 32'h11, 32'h70, 32'h0, 1'b0, 4'd3);
        mem_rd_addr = 5'd7; mem_rd_we = 1'b1; mem_is_load = 1'b1;
        #1;
        chk("lu_stall_valid", {31'd0, out_valid}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_stalls = exp_stalls + 32'd1;
            chk($sformatf("lu_stalls%0d", c), hazard_stalls, exp_stalls);
            chk($sformatf("lu_valid%0d", c), {31'd0, out_valid}, 32'd0);
        end
        idle_side();
        wb_rd_addr = 5'd7; wb_rd_we = 1'b1; wb_data = 32'hCAFE;
        out_ready = 1'b1;
        #1;
        chk("lu_resume_valid", {31'd0, out_valid}, 32'd1);
        chk("lu_resume_y", out_y, 32'hCAFE);
        tick();
        idle_side();
        out_ready = 1'b0;
        chk("lu_fired", {31'd0, out_valid}, 32'd0);
        chk("lu_stalls_final", hazard_stalls, exp_stalls);
`else
        // No bypass: stall on EX/MEM then MEM/WB producer, resume after write-back
        issue(5'd3, 5'd0, 32'h30, 32'h0, 32'h1, 1'b1, 4'd6);
        mem_rd_addr = 5'd3; mem_rd_we = 1'b1; mem_result = 32'h50;
        #1;
        chk("nf_mem_stall", {31'd0, out_valid}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            exp_stalls = exp_stalls + 32'd1;
            chk($sformatf("nf_stalls%0d", c), hazard_stalls, exp_stalls);
        end
        idle_side();
        wb_rd_addr = 5'd3; wb_rd_we = 1'b1; wb_data = 32'h77;
        #1;
        chk("nf_wb_stall", {31'd0, out_valid}, 32'd0);
        tick();
        exp_stalls = exp_stalls + 32'd1;
        idle_side();
        #1;
        chk("nf_resume_valid", {31'd0, out_valid}, 32'd1);
        chk("nf_resume_x", out_x, 32'h77);
        chk("nf_stalls_final", hazard_stalls, exp_stalls);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("nf_fired", {31'd0, out_valid}, 32'd0);
`endif

        // Flush during a hazard does not count as a stall cycle
        issue(5'd5, 5'd0, 32'h11, 32'h0, 32'h0, 1'b1, 4'd1);
        mem_rd_addr = 5'd5; mem_rd_we = 1'b1; mem_is_load = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_side();
        chk("hz_flush_stalls", hazard_stalls, exp_stalls);
        chk("hz_flush_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation discards the held instruction
        issue(5'd5, 5'd0, 32'h5A5A, 32'h0, 32'h0, 1'b1, 4'd1);
        #1;
        chk("midrst_before_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_stalls", hazard_stalls, 32'd0);
        chk("midrst_x", out_x, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
